// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p fetch path.
package cv32e40p_pkg;

   typedef enum logic [1:0] {
      ALIGNED32,
      MISALIGNED32,
      MISALIGNED16,
      BRANCH_MISALIGNED
   } fetch_align_state_e;

endpackage

// File: rtl/cv32e40p_fetch_aligner.sv
// Turns word-aligned fetch words into whole RV32IC instructions with their PC,
// splitting compressed pairs and stitching 32-bit instructions across words.
module cv32e40p_fetch_aligner
   import cv32e40p_pkg::*;
#(
   parameter bit PULP_XPULP = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] boot_addr_i,
   input  logic        fetch_valid_i,
   input  logic [31:0] fetch_rdata_i,
   output logic        fetch_ready_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_aligned_o,
   output logic        instr_compressed_o,
   output logic [31:0] pc_o,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   input  logic        hwlp_jump_i,
   input  logic [31:0] hwlp_target_i
);

   fetch_align_state_e state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [15:0]        hold_q, hold_d;
   logic               accept;
   logic               upper_is_32;
   logic               unused_boot_bit0;

   assign unused_boot_bit0 = boot_addr_i[0];

   assign upper_is_32 = (fetch_rdata_i[17:16] == 2'b11);
   assign accept      = instr_valid_o & instr_ready_i;

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      hold_d          = hold_q;
      instr_valid_o   = 1'b0;
      fetch_ready_o   = 1'b0;
      instr_aligned_o = fetch_rdata_i;

      unique case (state_q)
         ALIGNED32: begin
            instr_valid_o = fetch_valid_i;
            fetch_ready_o = instr_ready_i;
            if (fetch_rdata_i[1:0] == 2'b11) begin
               instr_aligned_o = fetch_rdata_i;
               if (accept) pc_d = pc_q + 32'd4;
            end else begin
               instr_aligned_o = {16'h0, fetch_rdata_i[15:0]};
               if (accept) begin
                  pc_d    = pc_q + 32'd2;
                  hold_d  = fetch_rdata_i[31:16];
                  state_d = upper_is_32 ? MISALIGNED32 : MISALIGNED16;
               end
            end
         end
         MISALIGNED32: begin
            instr_valid_o   = fetch_valid_i;
            fetch_ready_o   = instr_ready_i;
            instr_aligned_o = {fetch_rdata_i[15:0], hold_q};
            if (accept) begin
               pc_d    = pc_q + 32'd4;
               hold_d  = fetch_rdata_i[31:16];
               state_d = upper_is_32 ? MISALIGNED32 : MISALIGNED16;
            end
         end
         MISALIGNED16: begin
            // Held halfword is complete on its own; no fetch word needed.
            instr_valid_o   = 1'b1;
            instr_aligned_o = {16'h0, hold_q};
            if (accept) begin
               pc_d    = pc_q + 32'd2;
               state_d = ALIGNED32;
            end
         end
         BRANCH_MISALIGNED: begin
            instr_aligned_o = {16'h0, fetch_rdata_i[31:16]};
            if (!upper_is_32) begin
               instr_valid_o = fetch_valid_i;
               fetch_ready_o = instr_ready_i;
               if (accept) begin
                  pc_d    = pc_q + 32'd2;
                  state_d = ALIGNED32;
               end
            end else begin
               // Upper half starts a 32-bit instruction: swallow the word silently.
               fetch_ready_o = 1'b1;
               if (fetch_valid_i) begin
                  hold_d  = fetch_rdata_i[31:16];
                  state_d = MISALIGNED32;
               end
            end
         end
         default: begin
            state_d = ALIGNED32;
         end
      endcase

      if (PULP_XPULP && hwlp_jump_i && accept && !branch_i) begin
         pc_d    = hwlp_target_i;
         state_d = hwlp_target_i[1] ? BRANCH_MISALIGNED : ALIGNED32;
      end

      if (branch_i) begin
         instr_valid_o = 1'b0;
         fetch_ready_o = 1'b0;
         pc_d          = branch_addr_i;
         state_d       = branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED32;
      end

      if (!rst_n) begin
         instr_valid_o = fetch_valid_i;
         fetch_ready_o = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ALIGNED32;
         pc_q    <= {boot_addr_i[31:1], 1'b0};
         hold_q  <= 16'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
      end
   end

   assign instr_compressed_o = (instr_aligned_o[1:0] != 2'b11);
   assign pc_o               = pc_q;

endmodule

// File: doc/cv32e40p_fetch_aligner.md
Name: cv32e40p_fetch_aligner

Overview:
Stage directly downstream of the prefetch buffer. It consumes 32-bit word-aligned fetch words (fetch_valid/fetch_ready/fetch_rdata) and produces one whole RV32IC instruction per handshake, plus its PC, to the IF/ID pipeline register. It reassembles 32-bit instructions that straddle two fetch words, splits words holding two compressed instructions, and restarts cleanly on branches and hardware-loop jumps, including to halfword-aligned targets.

Parameters:
PULP_XPULP, 1, enables the hardware-loop jump inputs; when 0, hwlp_jump_i is ignored.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset, sampled on rising clk
boot_addr_i  in  32  PC loaded on reset; bit 0 ignored
fetch_valid_i  in  1  prefetch buffer word valid
fetch_rdata_i  in  32  prefetch buffer word
fetch_ready_o  out  1  pops the current fetch word
instr_valid_o  out  1  aligned instruction valid
instr_ready_i  in  1  ID accepts the instruction
instr_aligned_o  out  32  instruction; compressed ones zero-extended in [31:16]
instr_compressed_o  out  1  instr_aligned_o[1:0] != 2'b11
pc_o  out  32  PC of instr_aligned_o
branch_i  in  1  taken branch/jump/exception redirect
branch_addr_i  in  32  redirect target, halfword aligned
hwlp_jump_i  in  1  hardware-loop jump, qualified by accept of current instruction
hwlp_target_i  in  32  hardware-loop target, halfword aligned

Behaviour:
- Accept = instr_valid_o && instr_ready_i. Pop = fetch_valid_i && fetch_ready_o. All outputs are combinational from state, hold register and fetch inputs.
- Registers: state, pc_q[31:0], hold_q[15:0] (upper halfword of the previously popped word).
- Reset (rst_n low at clk edge): state=ALIGNED32, pc_q={boot_addr_i[31:1],1'b0}, hold_q=0. Outputs during reset follow from this state: instr_valid_o=fetch_valid_i, fetch_ready_o=0.
- ALIGNED32: instr_valid_o=fetch_valid_i.
  - If fetch_rdata_i[1:0]==11, emit the full word. On accept: pop, pc+=4, stay in ALIGNED32.
  - Otherwise emit the compressed instruction {16'h0, rdata[15:0]}. On accept: pop, hold_q=rdata[31:16], pc+=2. Next state is MISALIGNED32 if rdata[17:16]==11, else MISALIGNED16.
- MISALIGNED32: instr_valid_o=fetch_valid_i; instr={rdata[15:0],hold_q}. On accept: pop, hold_q=rdata[31:16], pc+=4, next state by rdata[17:16] as above.
- MISALIGNED16: instr_valid_o=1 regardless of fetch_valid_i; instr={16'h0,hold_q}; no pop. On accept: pc+=2, go to ALIGNED32.
- BRANCH_MISALIGNED (target bit 1 set): the lower half of the first word is discarded.
  - If rdata[17:16]!=11, emit {16'h0,rdata[31:16]} when fetch_valid_i. On accept: pop, pc+=2, go to ALIGNED32.
  - Otherwise instr_valid_o=0. On fetch_valid_i, pop without accept, hold_q=rdata[31:16], go to MISALIGNED32. pc is unchanged.
- fetch_ready_o = instr_ready_i in ALIGNED32 and MISALIGNED32; 0 in MISALIGNED16; in BRANCH_MISALIGNED, instr_ready_i for the compressed case and 1 for the 32-bit case. It is forced to 0 whenever branch_i=1.
- branch_i has top priority:
  - That cycle, instr_valid_o=0 and no pop.
  - Next: pc_q=branch_addr_i, state=BRANCH_MISALIGNED if branch_addr_i[1] else ALIGNED32.
  - hold_q is don't-care. The prefetch buffer flushes in the same cycle.
- hwlp_jump_i (PULP_XPULP=1) is honoured only with accept and no branch_i. The current instruction completes; the normal pop rules apply; then pc_q=hwlp_target_i and state is chosen by hwlp_target_i[1] as for a branch. Any held halfword is dropped.
- branch_i together with hwlp_jump_i: the branch wins.
- pc arithmetic is modulo 2^32 (wrap from 32'hFFFF_FFFE+2 to 0). pc_o=pc_q.
- instr_valid_o must never depend on instr_ready_i (no combinational loop to ID).

Decomposition:
- cv32e40p_pkg gets typedef enum logic [1:0] {ALIGNED32, MISALIGNED32, MISALIGNED16, BRANCH_MISALIGNED} fetch_align_state_e.
- No sub-module; the block is a single FSM plus datapath muxes.

Test Plan:
- Reset with boot_addr_i=32'h0000_0080, then words 32'h0041_0113 and 32'h0081_0193 with ready held 1 → two 32-bit instructions at pc 0x80 and 0x84, one pop each, instr_compressed_o=0.
- Word 32'h4501_4581 (two compressed) → 16'h4581 at pc X, then 16'h4501 at X+2 from MISALIGNED16 with fetch_ready_o=0; a single pop.
- Words 32'h0113_4581 then 32'h4501_0041 → 16'h4581 at X, then 32'h0041_0113 at X+2 (straddled), then 16'h4501 at X+6.
- branch_i with branch_addr_i=32'h0000_0202, then word 32'h0513_0000, then 32'hAAAA_0001 → low half discarded; first output is 32'h0001_0513 at pc 0x202 after two pops. branch_i during a pending instruction → instr_valid_o=0 that cycle.
- instr_ready_i held 0 for 5 cycles in MISALIGNED32 → outputs stable, no pop, pc unchanged.
- hwlp_jump_i with accept and hwlp_target_i=32'h100 while hold_q holds a compressed instruction → held halfword dropped; next output at pc 0x100. branch_i together with hwlp_jump_i → branch target used.
